// File: rtl/regfile_pkg.sv
// ==========================================================================
// regfile_pkg: shared defaults and types for the register file | Rev 1.0
// ==========================================================================
`default_nettype none

package regfile_pkg;

  localparam int RF_DATA_W   = 64;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = $clog2(RF_NUM_REGS);
  localparam int RF_NUM_RD   = 3;
  localparam int RF_ZERO_REG = 31;
  localparam int RF_MAX_PEND = 4;

  typedef logic [RF_ADDR_W-1:0] reg_addr_t;

endpackage

`default_nettype wire

// File: rtl/pend_scoreboard.sv
// ==========================================================================
// pend_scoreboard: per-register load-pending bits, count and busy lookup | Rev 1.0
// ==========================================================================
`default_nettype none

module pend_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = RF_ZERO_REG,
  parameter int MAX_PEND = RF_MAX_PEND,
  parameter int CNT_W    = $clog2(MAX_PEND + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_set,
  input  logic [ADDR_W-1:0]             i_set_addr,
  input  logic                          i_clr,
  input  logic [ADDR_W-1:0]             i_clr_addr,
  input  logic [NUM_RD-1:0][ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD-1:0]             o_busy,
  output logic                          o_ready,
  output logic [CNT_W-1:0]              o_count
);

  localparam logic [ADDR_W-1:0] c_ZERO = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  c_MAX  = CNT_W'(MAX_PEND);

  logic [NUM_REGS-1:0] r_pend;
  logic [CNT_W-1:0]    r_count;
  logic [NUM_REGS-1:0] w_pend_nxt;
  logic                w_ready;
  logic                w_set;
  logic                w_inc;
  logic                w_dec;

  assign w_ready = rst_n && (r_count < c_MAX);
  assign w_set   = i_set && w_ready && (i_set_addr != c_ZERO);
  // Count tracks the population of r_pend: a same-register set+clear nets to pending.
  assign w_inc   = w_set && !r_pend[i_set_addr];
  assign w_dec   = i_clr && r_pend[i_clr_addr] && !(w_set && (i_set_addr == i_clr_addr));

  always_comb begin
    w_pend_nxt = r_pend;
    if (i_clr) w_pend_nxt[i_clr_addr] = 1'b0;
    if (w_set) w_pend_nxt[i_set_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend  <= '0;
      r_count <= '0;
    end else begin
      r_pend  <= w_pend_nxt;
      r_count <= r_count + CNT_W'(w_inc) - CNT_W'(w_dec);
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_busy
    assign o_busy[gi] = rst_n && (i_rd_addr[gi] != c_ZERO) && r_pend[i_rd_addr[gi]]
                        && !(i_clr && (i_clr_addr == i_rd_addr[gi]));
  end

  assign o_ready = w_ready;
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ==========================================================================
// regfile_scoreboard: 2W/NR register file with bypass, XZR and load scoreboard | Rev 1.0
// ==========================================================================
`default_nettype none

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = RF_NUM_RD,
  parameter int ZERO_REG = RF_ZERO_REG,
  parameter int MAX_PEND = RF_MAX_PEND
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_RD-1:0][ADDR_W-1:0] RdAddr,
  output logic [NUM_RD-1:0][DATA_W-1:0] RdData,
  output logic [NUM_RD-1:0]             RdBusy,
  input  logic                          WrAEn,
  input  logic [ADDR_W-1:0]             WrAAddr,
  input  logic [DATA_W-1:0]             WrAData,
  input  logic                          WrBEn,
  input  logic [ADDR_W-1:0]             WrBAddr,
  input  logic [DATA_W-1:0]             WrBData,
  input  logic                          PendSet,
  input  logic [ADDR_W-1:0]             PendAddr,
  output logic                          PendReady,
  output logic [$clog2(MAX_PEND+1)-1:0] PendCount
);

  localparam int                CNT_W  = $clog2(MAX_PEND + 1);
  localparam logic [ADDR_W-1:0] c_ZERO = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // B is written first so A (the younger instruction) wins on an address clash.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
    end else begin
      if (WrBEn && (WrBAddr != c_ZERO)) r_regs[WrBAddr] <= WrBData;
      if (WrAEn && (WrAAddr != c_ZERO)) r_regs[WrAAddr] <= WrAData;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [DATA_W-1:0] w_rd_data;
    always_comb begin
      w_rd_data = r_regs[RdAddr[gi]];
      if (!rst_n || (RdAddr[gi] == c_ZERO))      w_rd_data = '0;
      else if (WrAEn && (WrAAddr == RdAddr[gi])) w_rd_data = WrAData;
      else if (WrBEn && (WrBAddr == RdAddr[gi])) w_rd_data = WrBData;
    end
    assign RdData[gi] = w_rd_data;
  end

  pend_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .MAX_PEND (MAX_PEND),
    .CNT_W    (CNT_W)
  ) u_pend (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set      (PendSet),
    .i_set_addr (PendAddr),
    .i_clr      (WrBEn),
    .i_clr_addr (WrBAddr),
    .i_rd_addr  (RdAddr),
    .o_busy     (RdBusy),
    .o_ready    (PendReady),
    .o_count    (PendCount)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ==========================================================================
// tb_regfile_scoreboard: directed scenarios plus randomized model check | Rev 1.0
// ==========================================================================
`default_nettype none

module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int NR = RF_NUM_RD;
  localparam int AW = RF_ADDR_W;
  localparam int DW = RF_DATA_W;
  localparam int CW = $clog2(RF_MAX_PEND + 1);

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NR-1:0][AW-1:0]     RdAddr;
  logic [NR-1:0][DW-1:0]     RdData;
  logic [NR-1:0]             RdBusy;
  logic                      WrAEn, WrBEn, PendSet;
  logic [AW-1:0]             WrAAddr, WrBAddr, PendAddr;
  logic [DW-1:0]             WrAData, WrBData;
  logic                      PendReady;
  logic [CW-1:0]             PendCount;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .RdAddr(RdAddr), .RdData(RdData), .RdBusy(RdBusy),
    .WrAEn(WrAEn), .WrAAddr(WrAAddr), .WrAData(WrAData),
    .WrBEn(WrBEn), .WrBAddr(WrBAddr), .WrBData(WrBData),
    .PendSet(PendSet), .PendAddr(PendAddr), .PendReady(PendReady), .PendCount(PendCount)
  );

  task automatic idle();
    WrAEn = 0; WrBEn = 0; PendSet = 0;
    WrAAddr = '0; WrBAddr = '0; PendAddr = '0; WrAData = '0; WrBData = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; idle(); RdAddr[0] = 5'd1; RdAddr[1] = 5'd2; RdAddr[2] = 5'd31;
    tick(); tick();
    #2;
    n_checks++; if (PendReady !== 1'b0) $display("FAIL rst_ready_low: got %b expected 0", PendReady); else n_pass++;
    rst_n = 1; tick(); #2;
    for (int i = 0; i < NR; i++) begin
      n_checks++;
      if (RdData[i] !== '0) $display("FAIL rst_rd%0d: got %h expected 0", i, RdData[i]); else n_pass++;
    end
    n_checks++; if (PendReady !== 1'b1) $display("FAIL rst_ready: got %b expected 1", PendReady); else n_pass++;
    n_checks++; if (PendCount !== 3'd0) $display("FAIL rst_count: got %0d expected 0", PendCount); else n_pass++;
  endtask

  task automatic test_bypass();
    tick();
    WrAEn = 1; WrAAddr = 5'd3; WrAData = 64'h1234; RdAddr[0] = 5'd3; #2;
    n_checks++; if (RdData[0] !== 64'h1234) $display("FAIL bypass_a: got %h expected 1234", RdData[0]); else n_pass++;
    tick(); idle(); #2;
    n_checks++; if (RdData[0] !== 64'h1234) $display("FAIL array_a: got %h expected 1234", RdData[0]); else n_pass++;
  endtask

  task automatic test_dual_write();
    WrAEn = 1; WrAAddr = 5'd5; WrAData = 64'hAAAA;
    WrBEn = 1; WrBAddr = 5'd5; WrBData = 64'hBBBB; RdAddr[0] = 5'd5; #2;
    n_checks++; if (RdData[0] !== 64'hAAAA) $display("FAIL dual_bypass: got %h expected aaaa", RdData[0]); else n_pass++;
    tick(); idle(); #2;
    n_checks++; if (RdData[0] !== 64'hAAAA) $display("FAIL dual_array: got %h expected aaaa", RdData[0]); else n_pass++;
    WrAEn = 1; WrAAddr = 5'd31; WrAData = 64'd7; RdAddr[1] = 5'd31; #2;
    n_checks++; if (RdData[1] !== '0) $display("FAIL xzr_bypass: got %h expected 0", RdData[1]); else n_pass++;
    tick(); idle(); #2;
    n_checks++; if (RdData[1] !== '0) $display("FAIL xzr_array: got %h expected 0", RdData[1]); else n_pass++;
  endtask

  task automatic test_pending();
    PendSet = 1; PendAddr = 5'd7; tick(); idle(); RdAddr[0] = 5'd7; #2;
    n_checks++; if (RdBusy[0] !== 1'b1) $display("FAIL pend_busy: got %b expected 1", RdBusy[0]); else n_pass++;
    n_checks++; if (PendCount !== 3'd1) $display("FAIL pend_count1: got %0d expected 1", PendCount); else n_pass++;
    WrBEn = 1; WrBAddr = 5'd7; WrBData = 64'h55; #2;
    n_checks++; if (RdBusy[0] !== 1'b0) $display("FAIL pend_wrb_busy: got %b expected 0", RdBusy[0]); else n_pass++;
    n_checks++; if (RdData[0] !== 64'h55) $display("FAIL pend_wrb_data: got %h expected 55", RdData[0]); else n_pass++;
    tick(); idle(); #2;
    n_checks++; if (PendCount !== 3'd0) $display("FAIL pend_count0: got %0d expected 0", PendCount); else n_pass++;
  endtask

  task automatic test_pend_full();
    for (int r = 1; r <= 4; r++) begin
      PendSet = 1; PendAddr = AW'(r); tick();
    end
    idle(); #2;
    n_checks++; if (PendCount !== 3'd4) $display("FAIL full_count: got %0d expected 4", PendCount); else n_pass++;
    n_checks++; if (PendReady !== 1'b0) $display("FAIL full_ready: got %b expected 0", PendReady); else n_pass++;
    PendSet = 1; PendAddr = 5'd6; tick(); idle(); RdAddr[1] = 5'd6; #2;
    n_checks++; if (RdBusy[1] !== 1'b0) $display("FAIL full_ignored_busy: got %b expected 0", RdBusy[1]); else n_pass++;
    n_checks++; if (PendCount !== 3'd4) $display("FAIL full_ignored_count: got %0d expected 4", PendCount); else n_pass++;
    PendSet = 1; PendAddr = 5'd8; WrBEn = 1; WrBAddr = 5'd1; WrBData = 64'h11;
    tick(); idle(); RdAddr[0] = 5'd8; RdAddr[1] = 5'd1; RdAddr[2] = 5'd2; #2;
    n_checks++; if (RdBusy !== 3'b100) $display("FAIL full_clear_busy: got %b expected 100", RdBusy); else n_pass++;
    n_checks++; if (PendCount !== 3'd3) $display("FAIL full_clear_count: got %0d expected 3", PendCount); else n_pass++;
  endtask

  task automatic test_set_clear_same();
    PendSet = 1; PendAddr = 5'd9; WrBEn = 1; WrBAddr = 5'd9; WrBData = 64'h99;
    tick(); idle(); RdAddr[0] = 5'd9; #2;
    n_checks++; if (RdBusy[0] !== 1'b1) $display("FAIL same_busy: got %b expected 1", RdBusy[0]); else n_pass++;
    n_checks++; if (RdData[0] !== 64'h99) $display("FAIL same_data: got %h expected 99", RdData[0]); else n_pass++;
    // X2, X3, X4 and X9 are now pending
    n_checks++; if (PendCount !== 3'd4) $display("FAIL same_count: got %0d expected 4", PendCount); else n_pass++;
  endtask

  task automatic test_reset_mid();
    rst_n = 0; WrAEn = 1; WrAAddr = 5'd10; WrAData = 64'hDEAD; RdAddr[1] = 5'd10; #2;
    n_checks++; if (RdData[0] !== '0 || RdBusy !== '0) $display("FAIL midrst_out: got %h/%b expected 0/0", RdData[0], RdBusy); else n_pass++;
    tick(); idle(); rst_n = 1; #2;
    n_checks++; if (RdData[0] !== '0 || RdData[1] !== '0) $display("FAIL midrst_data: got %h/%h expected 0/0", RdData[0], RdData[1]); else n_pass++;
    n_checks++; if (RdBusy !== '0) $display("FAIL midrst_busy: got %b expected 000", RdBusy); else n_pass++;
    n_checks++; if (PendCount !== 3'd0 || PendReady !== 1'b1) $display("FAIL midrst_pend: got %0d/%b expected 0/1", PendCount, PendReady); else n_pass++;
  endtask

  task automatic test_random();
    logic [DW-1:0] m_regs [RF_NUM_REGS];
    bit            m_pend [RF_NUM_REGS];
    int            cnt;
    logic [DW-1:0] exp_d;
    bit            exp_b, ready;
    rst_n = 0; idle(); tick(); rst_n = 1;
    for (int r = 0; r < RF_NUM_REGS; r++) begin m_regs[r] = '0; m_pend[r] = 0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst_n   = ($urandom_range(0, 79) != 0);
      WrAEn   = ($urandom_range(0, 2) == 0);
      WrAAddr = ($urandom_range(0, 9) == 0) ? AW'(31) : AW'($urandom_range(0, 11));
      WrAData = {$urandom, $urandom};
      WrBEn   = ($urandom_range(0, 2) == 0);
      WrBAddr = ($urandom_range(0, 9) == 0) ? AW'(31) : AW'($urandom_range(0, 11));
      WrBData = {$urandom, $urandom};
      PendSet = ($urandom_range(0, 1) == 0);
      PendAddr = ($urandom_range(0, 9) == 0) ? AW'(31) : AW'($urandom_range(0, 11));
      for (int i = 0; i < NR; i++)
        RdAddr[i] = ($urandom_range(0, 7) == 0) ? AW'(31) : AW'($urandom_range(0, 11));
      cnt = 0;
      for (int r = 0; r < RF_NUM_REGS; r++) cnt += int'(m_pend[r]);
      ready = rst_n && (cnt < RF_MAX_PEND);
      #2;
      for (int i = 0; i < NR; i++) begin
        if (!rst_n || RdAddr[i] == AW'(31))   exp_d = '0;
        else if (WrAEn && WrAAddr == RdAddr[i]) exp_d = WrAData;
        else if (WrBEn && WrBAddr == RdAddr[i]) exp_d = WrBData;
        else                                     exp_d = m_regs[RdAddr[i]];
        exp_b = rst_n && RdAddr[i] != AW'(31) && m_pend[RdAddr[i]] && !(WrBEn && WrBAddr == RdAddr[i]);
        n_checks++;
        if (RdData[i] !== exp_d) $display("FAIL rnd_data%0d cyc %0d: got %h expected %h", i, cyc, RdData[i], exp_d); else n_pass++;
        n_checks++;
        if (RdBusy[i] !== exp_b) $display("FAIL rnd_busy%0d cyc %0d: got %b expected %b", i, cyc, RdBusy[i], exp_b); else n_pass++;
      end
      n_checks++;
      if (PendReady !== ready) $display("FAIL rnd_ready cyc %0d: got %b expected %b", cyc, PendReady, ready); else n_pass++;
      n_checks++;
      if (PendCount !== CW'(cnt)) $display("FAIL rnd_count cyc %0d: got %0d expected %0d", cyc, PendCount, cnt); else n_pass++;
      @(posedge clk);
      if (!rst_n) begin
        for (int r = 0; r < RF_NUM_REGS; r++) begin m_regs[r] = '0; m_pend[r] = 0; end
      end else begin
        if (WrBEn && WrBAddr != AW'(31)) m_regs[WrBAddr] = WrBData;
        if (WrAEn && WrAAddr != AW'(31)) m_regs[WrAAddr] = WrAData;
        if (WrBEn) m_pend[WrBAddr] = 0;
        if (PendSet && ready && PendAddr != AW'(31)) m_pend[PendAddr] = 1;
      end
      #1;
    end
    rst_n = 1; idle();
  endtask

  initial begin
    rst_n = 0; idle(); RdAddr = '0;
    test_reset();
    test_bypass();
    test_dual_write();
    test_pending();
    test_pend_full();
    test_set_clear_same();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
